// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared core definitions used by the hazard controller and
//                the writeback pipeline: forward-select encoding, the
//                MEM-stage load FSM encoding and the default datapath width.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

   // Default datapath width
   localparam int CORE_XLEN = 32;

   // Forward-select encoding shared with the hazard controller
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_RSV = 2'b11;

   // MEM-stage load sequencer states
   typedef enum logic [0:0] {
      M_IDLE = 1'b0,
      M_WAIT = 1'b1
   } mem_state_e;

endpackage : core_pkg
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_mux
//  Description : 4:1 combinational operand select feeding one ALU input.
//                Reserved select (2'b11) falls back to register-file data.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
   import core_pkg::*;
#(
   parameter int XLEN = CORE_XLEN
)(
   input  logic [1:0]      i_sel,
   input  logic [XLEN-1:0] i_rf_data,
   input  logic [XLEN-1:0] i_wb_data,
   input  logic [XLEN-1:0] i_mem_data,
   output logic [XLEN-1:0] o_data
);

   // Select the operand source named by the hazard controller
   always_comb begin
      o_data = i_rf_data;
      case (i_sel)
         FWD_WB:  o_data = i_wb_data;
         FWD_MEM: o_data = i_mem_data;
         default: o_data = i_rf_data;
      endcase
   end

endmodule : fwd_mux
`default_nettype wire

// File: rtl/wbk_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : wbk_pipe
//  Description : MEM and WB pipeline registers, rd/wen publication to the
//                hazard controller, rs1/rs2 operand forwarding and the
//                multi-cycle load sequencer that stalls F/D/E while waiting.
//  Config      : WBK_LOAD_TIMEOUT_EN - adds a load-wait counter, the
//                TIMEOUT_CYCLES parameter and the o_dmem_err output.
//  Revision    : 1.0 - initial release
// ============================================================================
module wbk_pipe
   import core_pkg::*;
#(
   parameter int XLEN = CORE_XLEN
`ifdef WBK_LOAD_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 255
`endif
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_ex_valid,
   input  logic [4:0]      i_ex_rdidx,
   input  logic            i_ex_rdwen,
   input  logic            i_ex_is_load,
   input  logic [XLEN-1:0] i_ex_result,
   input  logic            i_dmem_rvalid,
   input  logic [XLEN-1:0] i_dmem_rdata,
   input  logic [1:0]      i_fwd_rs1_e,
   input  logic [1:0]      i_fwd_rs2_e,
   input  logic [XLEN-1:0] i_rs1_rdata,
   input  logic [XLEN-1:0] i_rs2_rdata,
   output logic [XLEN-1:0] o_rs1_fwd,
   output logic [XLEN-1:0] o_rs2_fwd,
   output logic [4:0]      o_rdidx_mem,
   output logic            o_rdwen_mem,
   output logic [4:0]      o_rdidx_wb,
   output logic            o_rdwen_wb,
   output logic [XLEN-1:0] o_wb_data,
   output logic            o_mem_busy
`ifdef WBK_LOAD_TIMEOUT_EN
   ,output logic           o_dmem_err
`endif
);

   mem_state_e      state_q,      state_d;
   logic [4:0]      mem_rdidx_q,  mem_rdidx_d;
   logic            mem_rdwen_q,  mem_rdwen_d;
   logic [XLEN-1:0] mem_result_q, mem_result_d;
   logic [4:0]      wb_rdidx_q,   wb_rdidx_d;
   logic            wb_rdwen_q,   wb_rdwen_d;
   logic [XLEN-1:0] wb_data_q,    wb_data_d;

   logic            w_in_wait;
   logic            w_timeout;
   logic            w_busy;
   logic [XLEN-1:0] w_mem_data;

   // MEM-stage data view: load data while waiting, ALU result otherwise
   always_comb begin
      w_in_wait  = (state_q == M_WAIT);
      w_mem_data = w_in_wait ? i_dmem_rdata : mem_result_q;
   end

`ifdef WBK_LOAD_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   // Timeout fires when the wait count has reached the limit; a same-cycle
   // rvalid takes priority and completes the load normally
   always_comb begin
      w_timeout = w_in_wait & ~i_dmem_rvalid & (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES));
   end

   // Count stalled wait cycles; any non-stalled edge (including M_WAIT entry) clears
   always_comb begin
      wait_cnt_d = '0;
      if (w_busy) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   // Wait counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign o_dmem_err = w_timeout;
`else
   // No timeout logic: the sequencer waits for rvalid indefinitely
   always_comb begin
      w_timeout = 1'b0;
   end
`endif

   // Stall while waiting for load data, unless this cycle completes or times out
   always_comb begin
      w_busy = w_in_wait & ~i_dmem_rvalid & ~w_timeout;
   end

   // Next-state logic for the load FSM and the MEM/WB pipeline registers
   always_comb begin
      state_d      = state_q;
      mem_rdidx_d  = mem_rdidx_q;
      mem_rdwen_d  = mem_rdwen_q;
      mem_result_d = mem_result_q;
      wb_rdidx_d   = wb_rdidx_q;
      wb_rdwen_d   = wb_rdwen_q;
      wb_data_d    = wb_data_q;
      if (w_busy) begin
         // MEM holds the pending load; WB retires its entry once, then bubbles
         wb_rdwen_d = 1'b0;
      end else begin
         // Writes to x0 are dropped here so they never appear on the interface
         mem_rdidx_d  = i_ex_rdidx;
         mem_rdwen_d  = i_ex_valid & i_ex_rdwen & (i_ex_rdidx != 5'd0);
         mem_result_d = i_ex_result;
         wb_rdidx_d   = mem_rdidx_q;
         wb_rdwen_d   = mem_rdwen_q & ~w_timeout;
         wb_data_d    = w_mem_data;
         state_d      = (i_ex_valid & i_ex_is_load) ? M_WAIT : M_IDLE;
      end
   end

   // State and pipeline register update
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= M_IDLE;
         mem_rdidx_q  <= 5'd0;
         mem_rdwen_q  <= 1'b0;
         mem_result_q <= '0;
         wb_rdidx_q   <= 5'd0;
         wb_rdwen_q   <= 1'b0;
         wb_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         mem_rdidx_q  <= mem_rdidx_d;
         mem_rdwen_q  <= mem_rdwen_d;
         mem_result_q <= mem_result_d;
         wb_rdidx_q   <= wb_rdidx_d;
         wb_rdwen_q   <= wb_rdwen_d;
         wb_data_q    <= wb_data_d;
      end
   end

   assign o_rdidx_mem = mem_rdidx_q;
   assign o_rdwen_mem = mem_rdwen_q;
   assign o_rdidx_wb  = wb_rdidx_q;
   assign o_rdwen_wb  = wb_rdwen_q;
   assign o_wb_data   = wb_data_q;
   assign o_mem_busy  = w_busy;

   fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
      .i_sel      (i_fwd_rs1_e),
      .i_rf_data  (i_rs1_rdata),
      .i_wb_data  (wb_data_q),
      .i_mem_data (w_mem_data),
      .o_data     (o_rs1_fwd)
   );

   fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
      .i_sel      (i_fwd_rs2_e),
      .i_rf_data  (i_rs2_rdata),
      .i_wb_data  (wb_data_q),
      .i_mem_data (w_mem_data),
      .o_data     (o_rs2_fwd)
   );

endmodule : wbk_pipe
`default_nettype wire
